// File: rtl/assoc_cache_ctrl_pkg.sv
// Shared types and helpers for the set-associative cache controller:
// FSM state encoding, default geometry and the true-LRU age update.
package cache_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_SETS       = 4;
  localparam int DEF_WAYS       = 2;
  localparam int DEF_WORDS      = 4;

  localparam int OFF_W = $clog2(DEF_WORDS);
  localparam int IDX_W = $clog2(DEF_SETS);
  localparam int TAG_W = DEF_ADDR_WIDTH - OFF_W - IDX_W;
  localparam int AGE_W = (DEF_WAYS > 1) ? $clog2(DEF_WAYS) : 1;

  // Ages live in fixed 2-bit slots so one helper serves 1, 2 and 4 ways.
  localparam int SLOT_W   = 2;
  localparam int MAX_WAYS = 4;
  localparam int LRU_W    = SLOT_W * MAX_WAYS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    WTHRU  = 2'd2,
    REFILL = 2'd3
  } state_t;

  function automatic logic [LRU_W-1:0] lru_update(input logic [LRU_W-1:0] ages,
                                                  input logic [1:0]       way,
                                                  input int               ways);
    logic [LRU_W-1:0]  res;
    logic [SLOT_W-1:0] cur;
    res = ages;
    cur = ages[SLOT_W*way +: SLOT_W];
    for (int i = 0; i < MAX_WAYS; i++) begin
      if (i < ways && ages[SLOT_W*i +: SLOT_W] < cur) begin
        res[SLOT_W*i +: SLOT_W] = ages[SLOT_W*i +: SLOT_W] + 2'd1;
      end else begin
        res[SLOT_W*i +: SLOT_W] = ages[SLOT_W*i +: SLOT_W];
      end
    end
    res[SLOT_W*way +: SLOT_W] = 2'd0;
    return res;
  endfunction

endpackage

// File: rtl/assoc_cache_ctrl_way_store.sv
// One cache way: per-set tag and valid bit plus the block data words.
// Writes are synchronous, reads combinational; only valid bits are reset.
module cache_way_store
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SETS       = DEF_SETS,
  parameter int WORDS      = DEF_WORDS,
  parameter int TAG_BITS   = TAG_W,
  parameter int IDX_BITS   = IDX_W,
  parameter int OFF_BITS   = OFF_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_all,
  input  logic                  inval,
  input  logic                  line_wr,
  input  logic [TAG_BITS-1:0]   tag_in,
  input  logic                  data_wr,
  input  logic [IDX_BITS-1:0]   idx,
  input  logic [OFF_BITS-1:0]   wr_off,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [OFF_BITS-1:0]   rd_off,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [SETS-1:0]       valid;
  logic [TAG_BITS-1:0]   tags [SETS];
  logic [DATA_WIDTH-1:0] data [SETS*WORDS];

  // Valid bits: flush clears all, install sets, a miss invalidates its victim.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (clear_all) begin
      valid <= '0;
    end else if (line_wr) begin
      valid[idx] <= 1'b1;
    end else if (inval) begin
      valid[idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (line_wr) begin
      tags[idx] <= tag_in;
    end
  end

  always_ff @(posedge clk) begin
    if (data_wr) begin
      data[{idx, wr_off}] <= wr_data;
    end
  end

  assign rd_valid = valid[idx];
  assign rd_tag   = tags[idx];
  assign rd_data  = data[{idx, rd_off}];

endmodule

// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative write-through / write-allocate cache controller
// with true-LRU replacement, pipelined block refill and bulk flush.
module assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SETS       = DEF_SETS,
  parameter int WAYS       = DEF_WAYS,
  parameter int WORDS      = DEF_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  flush,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_wr,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data
);

  localparam int OFF_BITS = $clog2(WORDS);
  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = ADDR_WIDTH - OFF_BITS - IDX_BITS;
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [OFF_BITS:0]   REQ_DONE = (OFF_BITS+1)'(WORDS);
  localparam logic [OFF_BITS-1:0] RSP_LAST = {OFF_BITS{1'b1}};

  state_t state, next_state;

  logic                  lat_wr;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [OFF_BITS:0]     req_cnt;
  logic [OFF_BITS-1:0]   rsp_cnt;
  logic [WAY_BITS-1:0]   victim;
  logic                  wr_done;
  logic [LRU_W-1:0]      ages [SETS];

  logic [TAG_BITS-1:0]   lat_tag;
  logic [IDX_BITS-1:0]   lat_idx;
  logic [OFF_BITS-1:0]   lat_off;

  logic [TAG_BITS-1:0]   way_tag  [WAYS];
  logic [DATA_WIDTH-1:0] way_data [WAYS];
  logic [WAYS-1:0]       way_valid;

  logic                  hit;
  logic [WAY_BITS-1:0]   hit_way;
  logic [DATA_WIDTH-1:0] hit_data;
  logic                  found;
  logic [WAY_BITS-1:0]   victim_sel;
  logic [SLOT_W-1:0]     max_age;
  logic [LRU_W-1:0]      set_ages;

  logic                  accept;
  logic                  clear_all;
  logic                  inval;
  logic                  start_refill;
  logic                  line_wr;
  logic                  data_wr;
  logic [WAY_BITS-1:0]   wr_way;
  logic [OFF_BITS-1:0]   wr_off;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_hit_rsp;
  logic                  lru_touch;
  logic [WAY_BITS-1:0]   touch_way;

  assign lat_tag  = lat_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign lat_idx  = lat_addr[OFF_BITS +: IDX_BITS];
  assign lat_off  = lat_addr[OFF_BITS-1:0];
  assign set_ages = ages[lat_idx];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_way_store #(
      .DATA_WIDTH(DATA_WIDTH),
      .SETS      (SETS),
      .WORDS     (WORDS),
      .TAG_BITS  (TAG_BITS),
      .IDX_BITS  (IDX_BITS),
      .OFF_BITS  (OFF_BITS)
    ) u_store (
      .clk      (clk),
      .rst      (rst),
      .clear_all(clear_all),
      .inval    (inval && (victim_sel == WAY_BITS'(g))),
      .line_wr  (line_wr && (victim == WAY_BITS'(g))),
      .tag_in   (lat_tag),
      .data_wr  (data_wr && (wr_way == WAY_BITS'(g))),
      .idx      (lat_idx),
      .wr_off   (wr_off),
      .wr_data  (wr_data),
      .rd_off   (lat_off),
      .rd_tag   (way_tag[g]),
      .rd_valid (way_valid[g]),
      .rd_data  (way_data[g])
    );
  end

  // Tag match across the set; first matching way wins.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && way_valid[w] && (way_tag[w] == lat_tag)) begin
        hit      = 1'b1;
        hit_way  = WAY_BITS'(w);
        hit_data = way_data[w];
      end else begin
        hit = hit;
      end
    end
  end

  // Victim: lowest invalid way, otherwise the oldest (lowest index on a tie).
  always_comb begin
    found      = 1'b0;
    victim_sel = '0;
    max_age    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !way_valid[w]) begin
        found      = 1'b1;
        victim_sel = WAY_BITS'(w);
      end else begin
        found = found;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (set_ages[SLOT_W*w +: SLOT_W] > max_age) begin
          max_age    = set_ages[SLOT_W*w +: SLOT_W];
          victim_sel = WAY_BITS'(w);
        end else begin
          max_age = max_age;
        end
      end
    end else begin
      max_age = '0;
    end
  end

  always_comb begin
    next_state    = state;
    req_ready     = 1'b0;
    accept        = 1'b0;
    clear_all     = 1'b0;
    inval         = 1'b0;
    start_refill  = 1'b0;
    line_wr       = 1'b0;
    data_wr       = 1'b0;
    wr_way        = '0;
    wr_off        = '0;
    wr_data       = '0;
    rd_hit_rsp    = 1'b0;
    lru_touch     = 1'b0;
    touch_way     = '0;
    mem_req_valid = 1'b0;
    mem_req_wr    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = !flush;
        if (flush) begin
          clear_all = 1'b1;
        end else if (req_valid) begin
          accept     = 1'b1;
          next_state = LOOKUP;
        end else begin
          next_state = IDLE;
        end
      end
      LOOKUP: begin
        if (hit) begin
          lru_touch = 1'b1;
          touch_way = hit_way;
          if (lat_wr) begin
            data_wr    = 1'b1;
            wr_way     = hit_way;
            wr_off     = lat_off;
            wr_data    = lat_wdata;
            next_state = WTHRU;
          end else begin
            rd_hit_rsp = 1'b1;
            next_state = IDLE;
          end
        end else begin
          inval        = 1'b1;
          start_refill = 1'b1;
          next_state   = REFILL;
        end
      end
      WTHRU: begin
        mem_req_valid = 1'b1;
        mem_req_wr    = 1'b1;
        mem_req_addr  = lat_addr;
        mem_req_wdata = lat_wdata;
        if (mem_req_ready) begin
          next_state = IDLE;
        end else begin
          next_state = WTHRU;
        end
      end
      REFILL: begin
        mem_req_valid = (req_cnt != REQ_DONE);
        mem_req_addr  = {lat_tag, lat_idx, req_cnt[OFF_BITS-1:0]};
        if (mem_rsp_valid) begin
          data_wr = 1'b1;
          wr_way  = victim;
          wr_off  = rsp_cnt;
          wr_data = mem_rsp_data;
          if (rsp_cnt == RSP_LAST) begin
            line_wr    = 1'b1;
            lru_touch  = 1'b1;
            touch_way  = victim;
            next_state = LOOKUP;
          end else begin
            next_state = REFILL;
          end
        end else begin
          next_state = REFILL;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign rsp_valid = rd_hit_rsp | wr_done;
  assign rsp_rdata = rd_hit_rsp ? hit_data : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      req_cnt   <= '0;
      rsp_cnt   <= '0;
      victim    <= '0;
      wr_done   <= 1'b0;
    end else begin
      state   <= next_state;
      wr_done <= (state == WTHRU) && mem_req_ready;
      if (accept) begin
        lat_wr    <= req_wr;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (start_refill) begin
        req_cnt <= '0;
        rsp_cnt <= '0;
        victim  <= victim_sel;
      end else if (state == REFILL) begin
        if (mem_req_valid && mem_req_ready) begin
          req_cnt <= req_cnt + 1'b1;
        end
        if (mem_rsp_valid) begin
          rsp_cnt <= rsp_cnt + 1'b1;
        end
      end
    end
  end

  // Ages are touched on a lookup hit and on line install.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        ages[s] <= '0;
      end
    end else if (lru_touch) begin
      ages[lat_idx] <= lru_update(set_ages, 2'(touch_way), WAYS);
    end
  end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed bench for assoc_cache_ctrl: 3-cycle in-order memory model with
// mem[a] = a ^ 16'hA5A5 plus write-through updates, table of transactions.
module tb_assoc_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [15:0] req_wdata = 16'h0000;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        flush = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic        mem_req_wr;
  logic [15:0] mem_req_addr;
  logic [15:0] mem_req_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [15:0] mem_rsp_data = 16'h0000;

  assoc_cache_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wr(mem_req_wr), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] data;
  } pend_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_reads;
    int          exp_writes;
    logic        exp_fast;
  } vec_t;

  pend_t       pend[$];
  logic [15:0] raddr_log[$];
  logic [15:0] wmem [logic [15:0]];
  int          cyc = 0;
  int          n_reads = 0;
  int          n_writes = 0;
  int          n_rsps = 0;
  int          n_dut_rsp = 0;
  logic [15:0] last_waddr = 16'h0000;
  logic [15:0] last_wdata = 16'h0000;
  int          total = 0;
  int          passed = 0;
  vec_t        vecs[13];

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    if (wmem.exists(a)) return wmem[a];
    return a ^ 16'hA5A5;
  endfunction

  // Memory: throttled ready, fixed 3-cycle read latency, never reset.
  always @(negedge clk) begin
    cyc = cyc + 1;
    mem_req_ready = (cyc % 3) != 2;
    if (mem_req_valid && mem_req_ready) begin
      if (mem_req_wr) begin
        wmem[mem_req_addr] = mem_req_wdata;
        last_waddr = mem_req_addr;
        last_wdata = mem_req_wdata;
        n_writes = n_writes + 1;
      end else begin
        raddr_log.push_back(mem_req_addr);
        pend.push_back('{cyc + 3, mem_val(mem_req_addr)});
        n_reads = n_reads + 1;
      end
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = pend[0].data;
      void'(pend.pop_front());
      n_rsps = n_rsps + 1;
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 16'h0000;
    end
    if (rsp_valid) n_dut_rsp = n_dut_rsp + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        output logic [15:0] rdata, output int lat,
                        output int reads, output int writes);
    int r0, w0, k;
    @(negedge clk);
    r0 = n_reads; w0 = n_writes;
    raddr_log.delete();
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    #1;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk); #1; k++;
    end
    check("accept timeout", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk); #1; lat++;
    end
    check("rsp timeout", {31'd0, rsp_valid}, 32'd1);
    rdata  = rsp_rdata;
    reads  = n_reads - r0;
    writes = n_writes - w0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [15:0] rdata, base, got;
    int lat, reads, writes;
    do_txn(v.wr, v.addr, v.wdata, rdata, lat, reads, writes);
    if (!v.wr) begin
      check("rdata", rdata, v.exp_rdata);
    end else begin
      check("wthru addr", last_waddr, v.addr);
      check("wthru data", last_wdata, v.wdata);
    end
    check("mem reads", reads, v.exp_reads);
    check("mem writes", writes, v.exp_writes);
    base = {v.addr[15:2], 2'b00};
    for (int i = 0; i < v.exp_reads; i++) begin
      got = (i < raddr_log.size()) ? raddr_log[i] : 16'hFFFF;
      check("refill addr", got, base + 16'(i));
    end
    if (v.exp_fast) check("hit latency", lat, 1);
  endtask

  initial begin
    vec_t v;
    int d0, r0, k;

    vecs[0]  = '{1'b0, 16'h0012, 16'h0000, 16'hA5B7, 4, 0, 1'b0};
    vecs[1]  = '{1'b0, 16'h0013, 16'h0000, 16'hA5B6, 0, 0, 1'b1};
    vecs[2]  = '{1'b1, 16'h0011, 16'h1234, 16'h0000, 0, 1, 1'b0};
    vecs[3]  = '{1'b0, 16'h0011, 16'h0000, 16'h1234, 0, 0, 1'b1};
    vecs[4]  = '{1'b0, 16'h0000, 16'h0000, 16'hA5A5, 4, 0, 1'b0};
    vecs[5]  = '{1'b0, 16'h0010, 16'h0000, 16'hA5B5, 0, 0, 1'b1};
    vecs[6]  = '{1'b0, 16'h0000, 16'h0000, 16'hA5A5, 0, 0, 1'b1};
    vecs[7]  = '{1'b0, 16'h0020, 16'h0000, 16'hA585, 4, 0, 1'b0};
    vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 16'hA5A5, 0, 0, 1'b1};
    vecs[9]  = '{1'b0, 16'h0010, 16'h0000, 16'hA5B5, 4, 0, 1'b0};
    vecs[10] = '{1'b1, 16'h0044, 16'hBEEF, 16'h0000, 4, 1, 1'b0};
    vecs[11] = '{1'b0, 16'h0044, 16'h0000, 16'hBEEF, 0, 0, 1'b1};
    vecs[12] = '{1'b0, 16'h0011, 16'h0000, 16'h1234, 0, 0, 1'b1};

    repeat (3) @(negedge clk);
    #1;
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("reset mem_req_wr", {31'd0, mem_req_wr}, 32'd0);
    check("reset mem_req_addr", mem_req_addr, 16'h0000);
    check("reset rsp_rdata", rsp_rdata, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Flush alone, then the previously cached block must refill.
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    v = '{1'b0, 16'h0012, 16'h0000, 16'hA5B7, 4, 0, 1'b0};
    run_vec(v);

    // Flush with a request in the same cycle: flush wins, request waits.
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0044;
    #1;
    check("flush+req ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    v = '{1'b0, 16'h0044, 16'h0000, 16'hBEEF, 4, 0, 1'b0};
    run_vec(v);

    // Reset after the second refill response.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0030;
    #1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    r0 = n_rsps; d0 = n_dut_rsp;
    #1;
    k = 0;
    while ((n_rsps - r0) < 2 && k < 50) begin
      @(negedge clk); #1; k++;
    end
    check("second refill rsp", n_rsps - r0, 2);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midreset req_ready", {31'd0, req_ready}, 32'd1);
    check("midreset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midreset mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("midreset mem_req_addr", mem_req_addr, 16'h0000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    k = 0;
    while (pend.size() > 0 && k < 20) begin
      @(negedge clk); k++;
    end
    repeat (2) @(negedge clk);
    #1;
    check("no rsp after reset", n_dut_rsp - d0, 0);
    v = '{1'b0, 16'h0030, 16'h0000, 16'hA595, 4, 0, 1'b0};
    run_vec(v);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/assoc_cache_ctrl.md
Name: assoc_cache_ctrl

Overview:
- Parametrised N-way set-associative cache with an internal tag, valid, LRU and data store, and its own miss-handling FSM.
- Next generation of the direct-mapped data/metadata array pair: adds configurable sets, ways and block size, true-LRU replacement, write-through with write-allocate, block refill from a multi-cycle memory, and a bulk flush.
- Sits between a pipeline memory stage (I- or D-side) and the arbitrated main memory port.

Parameters:
- ADDR_WIDTH, 16, word address width.
- DATA_WIDTH, 16, word width.
- SETS, 4, number of sets; power of two, ≥2.
- WAYS, 2, associativity; 1, 2 or 4.
- WORDS, 4, words per block; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  CPU request valid.
- req_ready  out  1  controller can accept a request.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle pulse: request complete.
- rsp_rdata  out  DATA_WIDTH  read data; valid only with rsp_valid on a read.
- flush  in  1  invalidate all lines; honoured only in IDLE.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_wr  out  1  memory write (write-through).
- mem_req_addr  out  ADDR_WIDTH  memory word address.
- mem_req_wdata  out  DATA_WIDTH  memory write data.
- mem_rsp_valid  in  1  read data returning; responses arrive in order.
- mem_rsp_data  in  DATA_WIDTH  read data.

Behaviour:
- Address split: offset = addr[log2(WORDS)-1:0]; index = next log2(SETS) bits; tag = remaining upper bits.
- Reset (rst=0, asynchronous):
  - state = IDLE; all valid bits = 0; all LRU ages = 0.
  - req_ready=1, rsp_valid=0, mem_req_valid=0, other outputs 0.
  - Data and tag arrays are not reset.
- IDLE: req_ready=1.
  - flush=1 with no request: all valid bits cleared next edge.
  - flush=1 together with req_valid: the flush wins and req_ready=0 that cycle.
  - req_valid & req_ready: latch wr/addr/wdata; go to LOOKUP.
- LOOKUP: compare the latched tag against all valid ways of the set.
  - Read hit: rsp_valid=1, rsp_rdata = hit word in the same cycle. Response arrives 1 cycle after acceptance. Update LRU, return to IDLE.
  - Write hit: write the word into the way, update LRU, go to WTHRU.
  - Miss (read or write): choose the victim = lowest-index invalid way, else the way with maximum age. Go to REFILL.
- WTHRU: mem_req_valid=1, mem_req_wr=1, addr/wdata = latched values. Held stable until mem_req_ready. On the accept edge: rsp_valid=1 in the next cycle, then IDLE.
- REFILL: issue WORDS reads at block_base+0..WORDS-1 in order.
  - req_cnt advances on each mem_req_valid & mem_req_ready.
  - rsp_cnt advances on each mem_rsp_valid and writes the word into the victim way.
  - Requests may be pipelined ahead of responses.
  - When rsp_cnt wraps after WORDS responses: set the victim tag, set valid, return to LOOKUP (replay). The replay always hits; a write-allocate then proceeds via WTHRU.
- No outstanding non-refill reads exist. mem_rsp_valid outside REFILL is ignored.
- LRU: per-way age of log2(WAYS) bits (0 = MRU). On hit or install of way w: ways with age < age[w] increment, age[w] = 0. WAYS=1: no LRU storage, victim is always way 0.
- req_ready=0 in every state except IDLE. Requests are never dropped or reordered.
- Reset mid-REFILL or mid-WTHRU:
  - Transaction is abandoned and no rsp_valid is produced.
  - The partially filled line stays invalid.
  - Memory responses arriving after reset are ignored.
- Tag and data arrays are single write-port per way. At most one array write per cycle.

Decomposition:
- Package cache_pkg: state enum (IDLE, LOOKUP, WTHRU, REFILL); localparams OFF_W, IDX_W, TAG_W, AGE_W derived from the parameters; function lru_update.
- One sub-module: cache_way_store, one instance per way, holding the tag/valid/data arrays with a synchronous write and a combinational read.

Test Plan:
- Defaults; memory with fixed 3-cycle latency, mem[a]=a^16'hA5A5. Cold read 0x0012 → reads 0x0010–0x0013 issued in order, rsp_rdata=0x A5B7, then re-read 0x0013 → hit, rsp_valid 1 cycle after accept, no mem traffic.
- Write 0x0011=16'h1234 after the above → mem write to 0x0011 data 0x1234; subsequent read 0x0011 is a hit returning 0x1234.
- LRU: read 0x0000, 0x0010, 0x0000, then 0x0020 (all set 0) → 0x0010's way evicted; read 0x0000 hits, read 0x0010 misses.
- Write miss 0x0044=16'hBEEF → refill of 0x0044–0x0047 then mem write; read 0x0044 hits, returns 0xBEEF.
- flush in IDLE after lines are cached → next read of 0x0012 misses and refills; flush asserted together with req_valid → req_ready=0 that cycle.
- Assert rst=0 after the second refill response → outputs at reset values immediately, no rsp_valid; read same address after reset → full 4-word refill.
